// File: rtl/ground_pkg.sv
// Shared types, tile ROM contents and colour expansion for the scrolling ground band.
package ground_pkg;

  typedef enum logic {ST_STOPPED = 1'b0, ST_RUN = 1'b1} state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       a;
  } px_t;

  // Tile ROM contents indexed [t][r][c]; each channel code is cdepth bits wide.
  function automatic px_t tile_px(int t, int r, int c, int cdepth);
    px_t p;
    int  m;
    m   = (1 << cdepth) - 1;
    p.r = 8'((r + 5 * t) & m);
    p.g = 8'((c ^ r) & m);
    p.b = 8'((c + 3 * t) & m);
    p.a = (((t + r + c) & 1) == 1);
    return p;
  endfunction

  // Left-align the stored code in 8 bits, zero-padded below.
  function automatic logic [7:0] expand(logic [7:0] code, int cdepth);
    return 8'(code << (8 - cdepth));
  endfunction

endpackage

// File: rtl/ground_scroller_if.sv
// Pixel request/response bundle between the renderer and the ground scroller.
interface ground_scroller_if;
  logic        in_valid;
  logic [10:0] ix;
  logic [10:0] iy;
  logic [7:0]  oR;
  logic [7:0]  oG;
  logic [7:0]  oB;
  logic        mask;
  logic        out_valid;

  modport master (output in_valid, ix, iy, input  oR, oG, oB, mask, out_valid);
  modport slave  (input  in_valid, ix, iy, output oR, oG, oB, mask, out_valid);
endinterface

// File: rtl/ground_tile_rom.sv
// Stage 2: registered tile lookup with colour expansion; holds its output when not enabled.
module ground_tile_rom
  import ground_pkg::*;
#(
  parameter int TILE_W = 16,
  parameter int TILE_H = 16,
  parameter int NTILES = 2,
  parameter int CDEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic                              band,
  input  logic [$clog2(TILE_W*NTILES)-1:0]  ex,
  input  logic [$clog2(TILE_H)-1:0]         row,
  output px_t                               px_q
);

  px_t raw, px_d;

  always_comb begin
    raw  = tile_px(int'(ex) / TILE_W, int'(row), int'(ex) % TILE_W, CDEPTH);
    px_d = px_q;
    if (en) begin
      px_d = '0;
      if (band) begin
        px_d.r = expand(raw.r, CDEPTH);
        px_d.g = expand(raw.g, CDEPTH);
        px_d.b = expand(raw.b, CDEPTH);
        px_d.a = raw.a;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) px_q <= '0;
    else     px_q <= px_d;
  end

endmodule

// File: rtl/ground_scroller.sv
// Scrolling ground band: run/stop FSM, per-frame offset counter and a 2-stage pixel pipeline.
module ground_scroller
  import ground_pkg::*;
#(
  parameter int TILE_W = 16,
  parameter int TILE_H = 16,
  parameter int NTILES = 2,
  parameter int CDEPTH = 4,
  parameter int Y0     = 448
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               stop,
  input  logic [3:0]         speed,
  ground_scroller_if.slave   pix,
  output logic               running,
  output logic [10:0]        scroll_off
);

  localparam int SPAN   = TILE_W * NTILES;
  localparam int OFF_W  = $clog2(SPAN);
  localparam int ROW_W  = $clog2(TILE_H);
  localparam int STAGES = 2;

  state_e              state_q, state_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic [OFF_W-1:0]    ex_q, ex_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic                band_q, band_d;
  logic [STAGES:1]     vld_pipe_q, vld_pipe_d;
  px_t                 px_q;

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    // A tick alongside stop still advances: the offset looks at the current state only.
    if (frame_tick && state_q == ST_RUN) off_d = OFF_W'(off_q + OFF_W'(speed));
    case (state_q)
      ST_STOPPED: if (start && !stop) state_d = ST_RUN;
      ST_RUN:     if (stop)           state_d = ST_STOPPED;
      default:                        state_d = ST_STOPPED;
    endcase

    ex_d   = ex_q;
    row_d  = row_q;
    band_d = band_q;
    if (pix.in_valid) begin
      ex_d   = OFF_W'(pix.ix + 11'(off_q));
      row_d  = ROW_W'(pix.iy - 11'(Y0));
      band_d = (pix.iy >= 11'(Y0)) && (pix.iy < 11'(Y0 + TILE_H));
    end
    vld_pipe_d = {vld_pipe_q[STAGES-1:1], pix.in_valid};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_STOPPED;
      off_q      <= '0;
      ex_q       <= '0;
      row_q      <= '0;
      band_q     <= 1'b0;
      vld_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      off_q      <= off_d;
      ex_q       <= ex_d;
      row_q      <= row_d;
      band_q     <= band_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  ground_tile_rom #(
    .TILE_W(TILE_W), .TILE_H(TILE_H), .NTILES(NTILES), .CDEPTH(CDEPTH)
  ) u_rom (
    .clk  (clk),
    .rst  (rst),
    .en   (vld_pipe_q[1]),
    .band (band_q),
    .ex   (ex_q),
    .row  (row_q),
    .px_q (px_q)
  );

  assign pix.oR        = px_q.r;
  assign pix.oG        = px_q.g;
  assign pix.oB        = px_q.b;
  assign pix.mask      = px_q.a;
  assign pix.out_valid = vld_pipe_q[STAGES];
  assign running       = (state_q == ST_RUN);
  assign scroll_off    = 11'(off_q);

endmodule

// File: tb/tb_ground_scroller.sv
// Scoreboard bench for ground_scroller: driver queues hand-computed pixels, a monitor pops on out_valid.
module tb_ground_scroller;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       m;
  } exp_t;

  // Entries: V0=[0][0][3], V1=[1][2][0], V3=[0][15][5], V4=[1][15][5], VZ=outside band.
  localparam exp_t V0 = {8'h00, 8'h30, 8'h30, 1'b1};
  localparam exp_t V1 = {8'h70, 8'h20, 8'h30, 1'b1};
  localparam exp_t V3 = {8'hF0, 8'hA0, 8'h50, 1'b0};
  localparam exp_t V4 = {8'h40, 8'hA0, 8'h80, 1'b1};
  localparam exp_t VZ = '0;

  logic        clk = 1'b0, rst = 1'b1;
  logic        frame_tick = 1'b0, start = 1'b0, stop = 1'b0;
  logic [3:0]  speed = 4'd0;
  logic        running;
  logic [10:0] scroll_off;

  exp_t        q[$];
  int          errs = 0, checks = 0;

  logic [10:0] xs[4] = '{11'd3, 11'd16, 11'd5, 11'd37};
  logic [10:0] ys[4] = '{11'd448, 11'd450, 11'd447, 11'd463};
  exp_t        es[4] = '{V0, V1, VZ, V3};

  ground_scroller_if pix();

  ground_scroller dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .start      (start),
    .stop       (stop),
    .speed      (speed),
    .pix        (pix),
    .running    (running),
    .scroll_off (scroll_off)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (pix.out_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_pixel: got %0h with nothing expected",
                 {pix.oR, pix.oG, pix.oB, pix.mask});
      end else begin
        e = q.pop_front();
        chk("pixel", 32'({pix.oR, pix.oG, pix.oB, pix.mask}), 32'(e));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [10:0] x, input logic [10:0] y, input exp_t e);
    pix.in_valid = 1'b1;
    pix.ix       = x;
    pix.iy       = y;
    q.push_back(e);
    cyc();
    pix.in_valid = 1'b0;
  endtask

  task automatic tick(input logic [3:0] s);
    speed      = s;
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  task automatic ctl(input string name, input logic [10:0] o, input logic r);
    @(negedge clk);
    chk({name, "_off"}, 32'(scroll_off), 32'(o));
    chk({name, "_run"}, 32'(running), 32'(r));
    cyc();
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      cyc();
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL drain: got %0d pixels still pending expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    pix.in_valid = 1'b0;
    pix.ix       = '0;
    pix.iy       = '0;

    repeat (2) cyc();
    @(negedge clk);
    chk("rst_out_valid", 32'(pix.out_valid), 32'd0);
    chk("rst_colour", 32'({pix.oR, pix.oG, pix.oB, pix.mask}), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_off", 32'(scroll_off), 32'd0);
    cyc();
    rst = 1'b0;

    req(11'd3, 11'd448, V0);
    drain();

    start = 1'b1; cyc(); start = 1'b0;
    ctl("start", 11'd0, 1'b1);
    repeat (3) tick(4'd5);
    ctl("speed5", 11'd15, 1'b1);
    req(11'd1, 11'd450, V1);
    drain();

    repeat (3) tick(4'd5);
    ctl("to30", 11'd30, 1'b1);
    tick(4'd4);
    ctl("wrap30", 11'd2, 1'b1);
    tick(4'd15);
    tick(4'd14);
    ctl("to31", 11'd31, 1'b1);
    tick(4'd3);
    ctl("wrap31", 11'd2, 1'b1);

    // Tick in the same cycle as a request: that pixel sees offset 2, the next sees 16.
    speed = 4'd14; frame_tick = 1'b1;
    pix.in_valid = 1'b1; pix.ix = 11'd14; pix.iy = 11'd450; q.push_back(V1);
    cyc();
    frame_tick = 1'b0;
    pix.ix = 11'd0; q.push_back(V1);
    cyc();
    pix.in_valid = 1'b0;
    ctl("tick_req", 11'd16, 1'b1);
    drain();

    req(11'd37, 11'd463, V4);
    req(11'd5, 11'd447, VZ);
    req(11'd5, 11'd464, VZ);
    drain();

    speed = 4'd14; frame_tick = 1'b1; stop = 1'b1;
    cyc();
    frame_tick = 1'b0; stop = 1'b0;
    ctl("tick_stop", 11'd30, 1'b0);
    tick(4'd7);
    ctl("tick_stopped", 11'd30, 1'b0);

    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    ctl("both_stopped", 11'd30, 1'b0);
    start = 1'b1; cyc(); start = 1'b0;
    ctl("restart", 11'd30, 1'b1);
    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    ctl("both_run", 11'd30, 1'b0);

    // Reset wins over start, tick and a request in the same cycle.
    start = 1'b1; cyc(); start = 1'b0;
    rst = 1'b1; start = 1'b1; frame_tick = 1'b1; speed = 4'd9;
    pix.in_valid = 1'b1; pix.ix = 11'd3; pix.iy = 11'd448;
    cyc();
    rst = 1'b0; start = 1'b0; frame_tick = 1'b0; pix.in_valid = 1'b0;
    ctl("rst_prio", 11'd0, 1'b0);
    repeat (3) cyc();
    drain();

    for (int i = 0; i < 64; i++) begin
      rst = (i == 20);
      if (i == 21 && q.size() != 0) q.delete(q.size() - 1);
      pix.in_valid = 1'b1;
      pix.ix = xs[i % 4];
      pix.iy = ys[i % 4];
      if (i != 20) q.push_back(es[i % 4]);
      if (i == 21 || i == 22) begin
        @(negedge clk);
        chk("rst_flush_valid", 32'(pix.out_valid), 32'd0);
      end
      cyc();
    end
    pix.in_valid = 1'b0;
    rst = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
